// File: rtl/bullet_pkg.sv
// ============================================================================
// Module      : bullet_pkg
// Description : Shared widths and FSM state type for the bullet scheduler
//               and bullet engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bullet_pkg;

    localparam int BULLET_X_W   = 12;
    localparam int BULLET_Y_W   = 11;
    localparam int SHOOTER_ID_W = 3;
    localparam int COOL_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        CALC = 2'd2
    } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; searches upward from
//               last_i+1 with wrap-around and returns the first requester.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import bullet_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]            req_i,
    input  logic [SHOOTER_ID_W-1:0] last_i,
    output logic [N-1:0]            gnt_o,
    output logic [SHOOTER_ID_W-1:0] idx_o,
    output logic                    any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int cand;
            cand = (int'(last_i) + k) % N;
            if (!any_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = SHOOTER_ID_W'(cand);
                any_o       = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bullet_scheduler.sv
// ============================================================================
// Module      : bullet_scheduler
// Description : Frame controller: drives the calc window and grants one
//               bullet insertion per frame with per-shooter cooldown.
//               Optional macro BULLET_SCHED_AUTOFIRE_EN: held button re-fires.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bullet_scheduler
    import bullet_pkg::*;
#(
    parameter int NUM_SHOOTERS = 4,
    parameter int COOLDOWN     = 6,
    parameter int CALC_MAX     = 4096
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               frame_start,
    input  logic [NUM_SHOOTERS-1:0]            fire_req,
    input  logic [NUM_SHOOTERS*BULLET_X_W-1:0] pos_x,
    input  logic [NUM_SHOOTERS*BULLET_Y_W-1:0] pos_y,
    input  logic                               engine_done,
    input  logic                               fire_ack,
    output logic                               calc,
    output logic                               fire_valid,
    output logic [BULLET_X_W-1:0]              fire_x,
    output logic [BULLET_Y_W-1:0]              fire_y,
    output logic [SHOOTER_ID_W-1:0]            fire_id,
    output logic                               overrun
);

    localparam int CNT_W = (CALC_MAX > 1) ? $clog2(CALC_MAX) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CALC_MAX - 1);
    localparam logic [COOL_W-1:0] COOL_INIT = COOL_W'(COOLDOWN);
    localparam logic [SHOOTER_ID_W-1:0] LAST_INIT = SHOOTER_ID_W'(NUM_SHOOTERS - 1);

    sched_state_e                state_q, state_d;
    logic                        calc_q, calc_d;
    logic                        valid_q, valid_d;
    logic [BULLET_X_W-1:0]       x_q, x_d;
    logic [BULLET_Y_W-1:0]       y_q, y_d;
    logic [SHOOTER_ID_W-1:0]     id_q, id_d;
    logic [SHOOTER_ID_W-1:0]     last_q, last_d;
    logic                        overrun_q, overrun_d;
    logic [NUM_SHOOTERS-1:0]     pending_q, pending_d;
    logic [NUM_SHOOTERS-1:0]     req_q;
    logic [NUM_SHOOTERS-1:0]     cz_q, cz_d;
    logic [COOL_W-1:0]           cool_q [NUM_SHOOTERS];
    logic [COOL_W-1:0]           cool_d [NUM_SHOOTERS];
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic [NUM_SHOOTERS-1:0]     w_set;
    logic [NUM_SHOOTERS-1:0]     w_elig;
    logic [NUM_SHOOTERS-1:0]     w_gnt;
    logic [SHOOTER_ID_W-1:0]     w_gnt_idx;
    logic                        w_gnt_any;
    logic [BULLET_X_W-1:0]       w_win_x;
    logic [BULLET_Y_W-1:0]       w_win_y;
    logic                        w_accept;
    logic [NUM_SHOOTERS-1:0]     w_accept_mask;
    logic                        w_win_end;

`ifdef BULLET_SCHED_AUTOFIRE_EN
    assign w_set = fire_req;
`else
    assign w_set = fire_req & ~req_q;
`endif

    // Cooldown zero-state is snapshotted at frame_start, before that frame's
    // decrement, so a shot re-arms exactly COOLDOWN+1 frames later.
    assign w_elig = pending_q & cz_q;

    rr_arbiter #(
        .N      (NUM_SHOOTERS)
    ) u_rr_arbiter (
        .req_i  (w_elig),
        .last_i (last_q),
        .gnt_o  (w_gnt),
        .idx_o  (w_gnt_idx),
        .any_o  (w_gnt_any)
    );

    always_comb begin
        w_win_x = '0;
        w_win_y = '0;
        for (int i = 0; i < NUM_SHOOTERS; i++) begin
            if (w_gnt[i]) begin
                w_win_x = pos_x[i*BULLET_X_W +: BULLET_X_W];
                w_win_y = pos_y[i*BULLET_Y_W +: BULLET_Y_W];
            end
        end
    end

    assign w_accept  = (state_q == CALC) && valid_q && fire_ack;
    assign w_win_end = (state_q == CALC) && (engine_done || (cnt_q == CNT_LAST));

    always_comb begin
        w_accept_mask = '0;
        for (int i = 0; i < NUM_SHOOTERS; i++) begin
            w_accept_mask[i] = w_accept && (id_q == SHOOTER_ID_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = ARB;
            ARB:     state_d = CALC;
            CALC:    if (w_win_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d   = valid_q;
        x_d       = x_q;
        y_d       = y_q;
        id_d      = id_q;
        last_d    = last_q;
        cz_d      = cz_q;
        calc_d    = (state_d == CALC);
        overrun_d = frame_start && (state_q != IDLE);
        cnt_d     = ((state_q == CALC) && !w_win_end) ? cnt_q + 1'b1 : '0;
        pending_d = (pending_q & ~w_accept_mask) | w_set;

        if ((state_q == ARB) && w_gnt_any) begin
            valid_d = 1'b1;
            x_d     = w_win_x;
            y_d     = w_win_y;
            id_d    = w_gnt_idx;
        end

        if (w_accept) begin
            valid_d = 1'b0;
            last_d  = id_q;
        end else if (w_win_end) begin
            valid_d = 1'b0;
        end

        for (int i = 0; i < NUM_SHOOTERS; i++) begin
            cool_d[i] = cool_q[i];
            if (frame_start) begin
                cz_d[i] = (cool_q[i] == '0);
                if (cool_q[i] != '0) cool_d[i] = cool_q[i] - 1'b1;
            end
            if (w_accept_mask[i]) cool_d[i] = COOL_INIT;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            calc_q    <= 1'b0;
            valid_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            id_q      <= '0;
            last_q    <= LAST_INIT;
            overrun_q <= 1'b0;
            pending_q <= '0;
            req_q     <= '0;
            cz_q      <= '1;
            cnt_q     <= '0;
            for (int i = 0; i < NUM_SHOOTERS; i++) cool_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            calc_q    <= calc_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            id_q      <= id_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
            pending_q <= pending_d;
            req_q     <= fire_req;
            cz_q      <= cz_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < NUM_SHOOTERS; i++) cool_q[i] <= cool_d[i];
        end
    end

    assign calc       = calc_q;
    assign fire_valid = valid_q;
    assign fire_x     = x_q;
    assign fire_y     = y_q;
    assign fire_id    = id_q;
    assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_bullet_scheduler.sv
// ============================================================================
// Module      : tb_bullet_scheduler
// Description : Directed self-checking bench for bullet_scheduler
//               (NUM_SHOOTERS=4, COOLDOWN=6, CALC_MAX=64).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bullet_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic [3:0]  fire_req = '0;
    logic [47:0] pos_x;
    logic [43:0] pos_y;
    logic        engine_done = 1'b0;
    logic        fire_ack = 1'b0;
    logic        calc;
    logic        fire_valid;
    logic [11:0] fire_x;
    logic [10:0] fire_y;
    logic [2:0]  fire_id;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    bullet_scheduler #(
        .NUM_SHOOTERS (4),
        .COOLDOWN     (6),
        .CALC_MAX     (64)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .fire_req    (fire_req),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .engine_done (engine_done),
        .fire_ack    (fire_ack),
        .calc        (calc),
        .fire_valid  (fire_valid),
        .fire_x      (fire_x),
        .fire_y      (fire_y),
        .fire_id     (fire_id),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation budget exhausted");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] m);
        fire_req = m;
        tick();
        fire_req = '0;
        tick();
    endtask

    // One frame: frame_start, ARB, then a calc window of len cycles ending
    // with engine_done; optionally acks on the first CALC cycle.
    task automatic run_frame(input bit do_ack, input int len, output bit g,
                             output logic [2:0] gid, output logic [11:0] gx,
                             output logic [10:0] gy);
        bit acked;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("calc_rise", calc, 1);
        g   = fire_valid;
        gid = fire_id;
        gx  = fire_x;
        gy  = fire_y;
        for (int c = 0; c < len; c++) begin
            acked       = do_ack && (c == 0) && fire_valid;
            fire_ack    = acked;
            engine_done = (c == len - 1);
            tick();
            fire_ack    = 1'b0;
            engine_done = 1'b0;
            if (acked) chk("valid_fall_after_ack", fire_valid, 0);
        end
        chk("calc_fall", calc, 0);
        chk("valid_idle", fire_valid, 0);
    endtask

    initial begin
        bit          g;
        logic [2:0]  gid;
        logic [11:0] gx;
        logic [10:0] gy;
        int          n;

        pos_x = {12'd7, 12'd4095, 12'd200, 12'd100};
        pos_y = {11'd9, 11'd2047, 11'd300, 11'd600};

        tick();
        tick();
        chk("rst_calc", calc, 0);
        chk("rst_valid", fire_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_x", fire_x, 0);
        chk("rst_y", fire_y, 0);
        chk("rst_id", fire_id, 0);
        reset = 1'b1;
        tick();

        // Shooter 0 single shot, then cooldown of 6 frames
        press(4'b0001);
        run_frame(1, 3, g, gid, gx, gy);
        chk("a_grant", g, 1);
        chk("a_x", gx, 100);
        chk("a_y", gy, 600);
        chk("a_id", gid, 0);
        press(4'b0001);
        for (int f = 1; f <= 7; f++) begin
            run_frame(1, 3, g, gid, gx, gy);
            chk($sformatf("a_cool_f%0d", f), g, (f == 7) ? 1 : 0);
        end
        chk("a_regrant_id", gid, 0);

        // Shooters 1 and 2 together: round-robin from last=0
        press(4'b0110);
        run_frame(1, 3, g, gid, gx, gy);
        chk("b1_grant", g, 1);
        chk("b1_id", gid, 1);
        chk("b1_x", gx, 200);
        chk("b1_y", gy, 300);
        run_frame(1, 3, g, gid, gx, gy);
        chk("b2_grant", g, 1);
        chk("b2_id", gid, 2);
        chk("b2_x", gx, 4095);
        chk("b2_y", gy, 2047);

        // Unacked grant is dropped with calc and re-granted next frame
        press(4'b1000);
        run_frame(0, 50, g, gid, gx, gy);
        chk("c_grant", g, 1);
        chk("c_id", gid, 3);
        run_frame(1, 3, g, gid, gx, gy);
        chk("c_regrant", g, 1);
        chk("c_regrant_id", gid, 3);
        chk("c_regrant_x", gx, 7);
        chk("c_regrant_y", gy, 9);

        // Watchdog window with an overrun frame_start inside it
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("d_overrun_pre", overrun, 0);
        n = 0;
        while (calc === 1'b1 && n < 200) begin
            n++;
            if (n == 10) frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            if (n == 10) chk("d_overrun_pulse", overrun, 1);
            if (n == 11) chk("d_overrun_clear", overrun, 0);
        end
        chk("d_calc_len", n, 64);
        tick();
        chk("d_calc_idle", calc, 0);
        run_frame(1, 2, g, gid, gx, gy);
        chk("d_nothing_pending", g, 0);

        // Async reset in the middle of a granted window
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        press(4'b0100);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("e_valid_before", fire_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("e_async_calc", calc, 0);
        chk("e_async_valid", fire_valid, 0);
        chk("e_async_x", fire_x, 0);
        tick();
        reset = 1'b1;
        tick();
        run_frame(1, 2, g, gid, gx, gy);
        chk("e_pending_cleared", g, 0);

        // Button held through reset counts as a press; last resets to N-1
        fire_req = 4'b0010;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        run_frame(1, 2, g, gid, gx, gy);
        chk("f_held_grant", g, 1);
        chk("f_held_id", gid, 1);
        for (int f = 1; f <= 14; f++) begin
            run_frame(1, 2, g, gid, gx, gy);
`ifdef BULLET_SCHED_AUTOFIRE_EN
            chk($sformatf("f_auto_f%0d", f), g, (f == 7 || f == 14) ? 1 : 0);
`else
            chk($sformatf("f_single_f%0d", f), g, 0);
`endif
        end
        fire_req = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
